// File: rtl/t03_display_timing_ctrl.sv
// Scan-timing controller: pixel divider, h/v counters, sync/blank decodes,
// end-of-line/frame strobes and a one-request-per-line prefetch handshake.
module t03_display_timing_ctrl #(
  parameter int STRETCH_COUNTER = 4,
  parameter int H_TOTAL         = 209,
  parameter int H_ACTIVE        = 160,
  parameter int H_FP            = 8,
  parameter int H_SYNC          = 16,
  parameter int V_TOTAL         = 120,
  parameter int V_ACTIVE        = 100,
  parameter int V_FP            = 4,
  parameter int V_SYNC          = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fetch_gnt,
  input  logic        fetch_done,
  input  logic        clr_underrun,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_tc,
  output logic        frame_tc,
  output logic        fetch_req,
  output logic [9:0]  fetch_line,
  output logic        underrun
);

  localparam int DIV_W = (STRETCH_COUNTER > 1) ? $clog2(STRETCH_COUNTER) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STRETCH_COUNTER - 1);

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_TRIG     = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  logic [DIV_W-1:0] div_reg;
  logic [10:0]      hcnt_reg;
  logic [9:0]       vcnt_reg;
  logic             line_tc_reg;
  logic             frame_tc_reg;
  logic [9:0]       fetch_line_reg;
  logic             underrun_reg;
  state_t           state_reg;
  state_t           state_next;

  logic       pix_tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] next_line;
  logic       trigger;
  logic       underrun_set;

  assign pix_tick  = en && (div_reg == DIV_LAST);
  assign h_wrap    = pix_tick && (hcnt_reg >= H_LAST);
  assign v_wrap    = (vcnt_reg >= V_LAST);
  assign next_line = v_wrap ? 10'd0 : vcnt_reg + 10'd1;

  // Prefetch fires as the column enters horizontal blanking, for the line after this one.
  assign trigger      = pix_tick && (hcnt_reg == H_TRIG) && (next_line < V_ACT);
  assign underrun_set = trigger && (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg      <= '0;
      hcnt_reg     <= '0;
      vcnt_reg     <= '0;
      line_tc_reg  <= 1'b0;
      frame_tc_reg <= 1'b0;
    end else begin
      if (en) begin
        div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      end
      if (pix_tick) begin
        hcnt_reg <= h_wrap ? 11'd0 : hcnt_reg + 11'd1;
        if (h_wrap) begin
          vcnt_reg <= v_wrap ? 10'd0 : vcnt_reg + 10'd1;
        end
      end
      line_tc_reg  <= h_wrap;
      frame_tc_reg <= h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Done is only meaningful once granted; a done arriving with the grant is dropped.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (trigger)    state_next = REQ;
      REQ:     if (fetch_gnt)  state_next = BUSY;
      BUSY:    if (fetch_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_req = (state_reg == REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_line_reg <= '0;
      underrun_reg   <= 1'b0;
    end else begin
      if (trigger && (state_reg == IDLE)) begin
        fetch_line_reg <= next_line;
      end
      if (underrun_set) begin
        underrun_reg <= 1'b1;
      end else if (clr_underrun) begin
        underrun_reg <= 1'b0;
      end
    end
  end

  assign hcnt       = hcnt_reg;
  assign vcnt       = vcnt_reg;
  assign line_tc    = line_tc_reg;
  assign frame_tc   = frame_tc_reg;
  assign fetch_line = fetch_line_reg;
  assign underrun   = underrun_reg;

  assign active = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
  assign hsync  = !((hcnt_reg >= HS_START) && (hcnt_reg < HS_END));
  assign vsync  = !((vcnt_reg >= VS_START) && (vcnt_reg < VS_END));

endmodule

// File: tb/tb_t03_display_timing_ctrl.sv
// Bench for the scan-timing controller, using a shrunken raster so whole frames fit
// in a short run; the reference derives position from the count of enabled clocks.
module tb_t03_display_timing_ctrl;

  localparam int S   = 2;
  localparam int HT  = 30;
  localparam int HA  = 20;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VS  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        fetch_gnt = 1'b0;
  logic        fetch_done = 1'b0;
  logic        clr_underrun = 1'b0;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        line_tc;
  logic        frame_tc;
  logic        fetch_req;
  logic [9:0]  fetch_line;
  logic        underrun;

  t03_display_timing_ctrl #(
    .STRETCH_COUNTER(S), .H_TOTAL(HT), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .clr_underrun(clr_underrun), .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync),
    .vsync(vsync), .active(active), .line_tc(line_tc), .frame_tc(frame_tc),
    .fetch_req(fetch_req), .fetch_line(fetch_line), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: raster position is the number of pixel ticks since reset.
  int en_clks;
  int m_fetch;      // 0 nothing outstanding, 1 requested, 2 granted
  int m_line;
  bit m_und;
  bit m_ltc;
  bit m_ftc;

  function automatic int pix_h(int clks);
    return (clks / S) % HT;
  endfunction

  function automatic int pix_v(int clks);
    return ((clks / S) / HT) % VT;
  endfunction

  function automatic bit will_trigger();
    int nc;
    if (!(en && (en_clks % S == S - 1))) return 1'b0;
    nc = en_clks + 1;
    return (pix_h(nc) == HA) && (((pix_v(nc) + 1) % VT) < VA);
  endfunction

  task automatic model_reset();
    en_clks = 0;
    m_fetch = 0;
    m_line  = 0;
    m_und   = 1'b0;
    m_ltc   = 1'b0;
    m_ftc   = 1'b0;
  endtask

  task automatic model_update();
    bit tick;
    bit trig;
    int v_old;
    int nxt;
    int old;
    tick  = en && (en_clks % S == S - 1);
    v_old = pix_v(en_clks);
    if (en) en_clks++;
    m_ltc = tick && (pix_h(en_clks) == 0);
    m_ftc = m_ltc && (pix_v(en_clks) == 0);
    nxt   = (v_old + 1) % VT;
    trig  = tick && (pix_h(en_clks) == HA) && (nxt < VA);
    old   = m_fetch;
    if (old == 0 && trig) begin
      m_fetch = 1;
      m_line  = nxt;
    end else if (old == 1 && fetch_gnt) begin
      m_fetch = 2;
    end else if (old == 2 && fetch_done) begin
      m_fetch = 0;
    end
    if (trig && old != 0) m_und = 1'b1;
    else if (clr_underrun) m_und = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int h;
    int v;
    h = pix_h(en_clks);
    v = pix_v(en_clks);
    check("hcnt", hcnt, h);
    check("vcnt", vcnt, v);
    check("active", active, (h < HA) && (v < VA));
    check("hsync", hsync, !((h >= HA + HFP) && (h < HA + HFP + HS)));
    check("vsync", vsync, !((v >= VA + VFP) && (v < VA + VFP + VS)));
    check("line_tc", line_tc, m_ltc);
    check("frame_tc", frame_tc, m_ftc);
    check("fetch_req", fetch_req, m_fetch == 1);
    check("fetch_line", fetch_line, m_line);
    check("underrun", underrun, m_und);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      en           = ($urandom % 10) != 0;
      fetch_gnt    = ($urandom % 3) == 0;
      fetch_done   = ($urandom % 4) == 0;
      clr_underrun = ($urandom % 40) == 0;
      step();
    end
  endtask

  initial begin
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_hsync", hsync, 1);
    check("reset_active", active, 1);
    check_all();
    rst = 1'b1;

    // Random traffic over about two frames.
    run_random(1500);

    // Fetch never completes: every later trigger is a miss.
    en = 1'b1; fetch_gnt = 1'b1; fetch_done = 1'b0; clr_underrun = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      found = m_und;
    end
    check("underrun_set", underrun, 1);

    // Clear coinciding with a new miss: the set must win.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      clr_underrun = will_trigger();
      found = clr_underrun;
      step();
    end
    check("trigger_found", found, 1);
    check("set_beats_clr", underrun, 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    check("clr_alone", underrun, 0);

    // Freeze timing while the fetch stays outstanding.
    en = 1'b0;
    repeat (50) step();
    check("still_busy", m_fetch, 2);

    // Asynchronous reset between clock edges, mid-fetch.
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    run_random(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
